// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions: response codes and the command master FSM states.
package axi4l_pkg;

    localparam logic [1:0] AXI4L_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4L_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI4L_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI4L_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        MST_IDLE,
        MST_WR_REQ,
        MST_WR_RESP,
        MST_RD_REQ,
        MST_RD_RESP,
        MST_RSP
    } axi4l_mst_state_t;

endpackage

// File: rtl/axi4l_cmd_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one AXI transaction,
// one response out. A stuck slave is abandoned after TIMEOUT_CYCLES with an SLVERR response.
module axi4l_cmd_master
    import axi4l_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rstn,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,

    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit TO_EN      = (TIMEOUT_CYCLES > 0);
    localparam int TO_W       = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    axi4l_mst_state_t        r_state;
    logic                    r_cmd_ready;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]              r_rsp_resp;
    logic                    r_rsp_timeout;
    logic [TO_W-1:0]         r_cnt;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;

    logic w_cmd_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_rsp_hs;
    logic w_timeout;

    assign w_cmd_hs  = r_cmd_ready & cmd_valid;
    assign w_aw_hs   = r_awvalid & m_axi_awready;
    assign w_w_hs    = r_wvalid & m_axi_wready;
    // A channel counts as done if it already handshook earlier or handshakes this cycle.
    assign w_aw_done = ~r_awvalid | m_axi_awready;
    assign w_w_done  = ~r_wvalid | m_axi_wready;
    assign w_b_hs    = r_bready & m_axi_bvalid;
    assign w_ar_hs   = r_arvalid & m_axi_arready;
    assign w_r_hs    = r_rready & m_axi_rvalid;
    assign w_rsp_hs  = r_rsp_valid & rsp_ready;
    assign w_timeout = TO_EN && (r_cnt >= TO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= MST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= AXI4L_RESP_OKAY;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                MST_IDLE: begin
                    if (w_cmd_hs) begin
                        r_cmd_ready <= 1'b0;
                        r_cnt       <= '0;
                        if (cmd_rnw) begin
                            r_arvalid <= 1'b1;
                            r_state   <= MST_RD_REQ;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= MST_WR_REQ;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                MST_WR_REQ: begin
                    r_cnt <= r_cnt + TO_W'(1);
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= MST_WR_RESP;
                    end else if (w_timeout) begin
                        r_awvalid     <= 1'b0;
                        r_wvalid      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= AXI4L_RESP_SLVERR;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= MST_RSP;
                    end
                end

                MST_WR_RESP: begin
                    r_cnt <= r_cnt + TO_W'(1);
                    if (w_b_hs) begin
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= m_axi_bresp;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= MST_RSP;
                    end else if (w_timeout) begin
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= AXI4L_RESP_SLVERR;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= MST_RSP;
                    end
                end

                MST_RD_REQ: begin
                    r_cnt <= r_cnt + TO_W'(1);
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= MST_RD_RESP;
                    end else if (w_timeout) begin
                        r_arvalid     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= AXI4L_RESP_SLVERR;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= MST_RSP;
                    end
                end

                MST_RD_RESP: begin
                    r_cnt <= r_cnt + TO_W'(1);
                    if (w_r_hs) begin
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= m_axi_rdata;
                        r_rsp_resp    <= m_axi_rresp;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= MST_RSP;
                    end else if (w_timeout) begin
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= AXI4L_RESP_SLVERR;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= MST_RSP;
                    end
                end

                MST_RSP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= MST_IDLE;
                    end
                end

                default: begin
                    r_state <= MST_IDLE;
                end
            endcase
        end
    end

    // Command payload is pure data: captured on accept, held for the whole transaction.
    always_ff @(posedge clk) begin
        if (w_cmd_hs) begin
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_wstrb <= cmd_wstrb;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi4l_cmd_master.sv
// Directed bench for axi4l_cmd_master against a small behavioral AXI4-Lite register slave.
module tb_axi4l_cmd_master;
    import axi4l_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int vec = 0;
    int miscmp = 0;
    int cyc = 0;

    axi4l_cmd_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: 16 words at offsets 0x00-0x3F, DECERR elsewhere; readies gated by wait counts.
    logic [31:0] mem [16];
    int aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0, b_count = 0;
    bit ar_block = 1'b0;
    logic aw_got, w_got;

    assign m_axi_awready = (aw_cnt >= aw_dly);
    assign m_axi_wready  = (w_cnt >= w_dly);
    assign m_axi_arready = !ar_block;

    function automatic logic mapped(input logic [31:0] a);
        return (a[15:0] < 16'h0040);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
            m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
        end else begin
            if (m_axi_awvalid && !m_axi_awready) aw_cnt <= aw_cnt + 1;
            else if (m_axi_awvalid && m_axi_awready) aw_cnt <= 0;
            if (m_axi_wvalid && !m_axi_wready) w_cnt <= w_cnt + 1;
            else if (m_axi_wvalid && m_axi_wready) w_cnt <= 0;
            if ((aw_got || (m_axi_awvalid && m_axi_awready)) &&
                (w_got || (m_axi_wvalid && m_axi_wready))) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (mapped(m_axi_awaddr)) begin
                    for (int b = 0; b < 4; b++)
                        if (m_axi_wstrb[b]) mem[m_axi_awaddr[5:2]][b*8 +: 8] <= m_axi_wdata[b*8 +: 8];
                    m_axi_bresp <= AXI4L_RESP_OKAY;
                end else begin
                    m_axi_bresp <= AXI4L_RESP_DECERR;
                end
                m_axi_bvalid <= 1'b1;
            end else begin
                if (m_axi_awvalid && m_axi_awready) aw_got <= 1'b1;
                if (m_axi_wvalid && m_axi_wready)   w_got  <= 1'b1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 1'b0;
                b_count <= b_count + 1;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= mapped(m_axi_araddr) ? mem[m_axi_araddr[5:2]] : 32'h0;
                m_axi_rresp  <= mapped(m_axi_araddr) ? AXI4L_RESP_OKAY : AXI4L_RESP_DECERR;
            end else if (m_axi_rvalid && m_axi_rready) begin
                m_axi_rvalid <= 1'b0;
            end
        end
    end

    task automatic send_cmd(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int acc);
        @(negedge clk);
        cmd_rnw = rnw; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            vec++; miscmp++;
            $display("FAIL cmd_accept_wait: cmd_ready stayed 0, required 1 within 40 cycles");
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int seen);
        seen = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) begin
            vec++; miscmp++;
            $display("FAIL rsp_wait: rsp_valid stayed 0, required 1 within 60 cycles");
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic do_cmd(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic [1:0] resp,
                          output logic [31:0] rdata, output logic to);
        int acc, seen;
        send_cmd(rnw, a, d, s, acc);
        wait_rsp(seen);
        lat = seen - acc;
        resp = rsp_resp; rdata = rsp_rdata; to = rsp_timeout;
        consume();
    endtask

    // Write with per-cycle monitoring of how long each request valid stays up.
    task automatic write_mon(input logic [31:0] a, input logic [31:0] d, output int aw_hi,
                             output int w_hi, output int lat, output bit held,
                             output logic [1:0] resp);
        int acc, seen;
        bit aw_done, w_done;
        aw_hi = 0; w_hi = 0; held = 1'b1; aw_done = 1'b0; w_done = 1'b0; seen = -1;
        send_cmd(1'b0, a, d, 4'hF, acc);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = cyc;
                break;
            end
            if (!aw_done) begin
                if (!m_axi_awvalid) held = 1'b0;
                else aw_hi++;
                if (m_axi_awvalid && m_axi_awready) aw_done = 1'b1;
            end
            if (!w_done) begin
                if (!m_axi_wvalid) held = 1'b0;
                else w_hi++;
                if (m_axi_wvalid && m_axi_wready) w_done = 1'b1;
            end
        end
        if (seen < 0) begin
            vec++; miscmp++;
            $display("FAIL write_mon_wait: rsp_valid stayed 0, required 1 within 40 cycles");
        end
        lat = seen - acc;
        resp = rsp_resp;
        consume();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vec++; if (cmd_ready !== 1'b0) begin miscmp++;
            $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready); end
        vec++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
            miscmp++; $display("FAIL reset_axi_handshakes: got %b, required 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}); end
        vec++; if (rsp_valid !== 1'b0) begin miscmp++;
            $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        vec++; if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'h0) begin miscmp++;
            $display("FAIL reset_rsp_data: got rdata=%h resp=%b to=%b, required all 0",
                rsp_rdata, rsp_resp, rsp_timeout); end
        rstn = 1'b1;
        #1;
        vec++; if (cmd_ready !== 1'b0) begin miscmp++;
            $display("FAIL release_cmd_ready_early: got %b, required 0 before first edge", cmd_ready); end
        @(negedge clk);
        vec++; if (cmd_ready !== 1'b1) begin miscmp++;
            $display("FAIL release_cmd_ready: got %b, required 1 after first edge", cmd_ready); end
    endtask

    task automatic test_write_read();
        int lat; logic [1:0] resp; logic [31:0] rd; logic to;
        do_cmd(1'b0, 32'h8000_0000, 32'hA5A5_0001, 4'hF, lat, resp, rd, to);
        vec++; if (lat !== 3) begin miscmp++; $display("FAIL wr_latency: got %0d, required 3", lat); end
        vec++; if ({resp, to, rd} !== {AXI4L_RESP_OKAY, 1'b0, 32'h0}) begin miscmp++;
            $display("FAIL wr_rsp: got resp=%b to=%b rdata=%h, required 00 0 00000000", resp, to, rd); end
        do_cmd(1'b1, 32'h8000_0000, 32'h0, 4'h0, lat, resp, rd, to);
        vec++; if (lat !== 3) begin miscmp++; $display("FAIL rd_latency: got %0d, required 3", lat); end
        vec++; if ({resp, to} !== {AXI4L_RESP_OKAY, 1'b0}) begin miscmp++;
            $display("FAIL rd_resp: got resp=%b to=%b, required 00 0", resp, to); end
        vec++; if (rd !== 32'hA5A5_0001) begin miscmp++;
            $display("FAIL rd_data: got %h, required a5a50001", rd); end
        do_cmd(1'b0, 32'h8000_0000, 32'h1122_3344, 4'b0101, lat, resp, rd, to);
        do_cmd(1'b1, 32'h8000_0000, 32'h0, 4'h0, lat, resp, rd, to);
        vec++; if (rd !== 32'hA522_0044) begin miscmp++;
            $display("FAIL strobe_merge: got %h, required a5220044", rd); end
    endtask

    task automatic test_split_write();
        int aw_hi, w_hi, lat, b0, lat2; bit held; logic [1:0] resp; logic [31:0] rd; logic to;
        aw_dly = 0; w_dly = 5; b0 = b_count;
        write_mon(32'h8000_0004, 32'hDEAD_BEEF, aw_hi, w_hi, lat, held, resp);
        vec++; if ({held, aw_hi, w_hi} !== {1'b1, 32'd1, 32'd6}) begin miscmp++;
            $display("FAIL split_w_late: got held=%b aw_hi=%0d w_hi=%0d, required 1 1 6", held, aw_hi, w_hi); end
        vec++; if (b_count - b0 !== 1) begin miscmp++;
            $display("FAIL split_w_late_bcount: got %0d, required 1", b_count - b0); end
        vec++; if ({resp, lat} !== {AXI4L_RESP_OKAY, 32'd8}) begin miscmp++;
            $display("FAIL split_w_late_rsp: got resp=%b lat=%0d, required 00 8", resp, lat); end
        aw_dly = 5; w_dly = 0; b0 = b_count;
        write_mon(32'h8000_0008, 32'h0BAD_F00D, aw_hi, w_hi, lat, held, resp);
        vec++; if ({held, aw_hi, w_hi} !== {1'b1, 32'd6, 32'd1}) begin miscmp++;
            $display("FAIL split_aw_late: got held=%b aw_hi=%0d w_hi=%0d, required 1 6 1", held, aw_hi, w_hi); end
        vec++; if (b_count - b0 !== 1) begin miscmp++;
            $display("FAIL split_aw_late_bcount: got %0d, required 1", b_count - b0); end
        vec++; if (resp !== AXI4L_RESP_OKAY) begin miscmp++;
            $display("FAIL split_aw_late_rsp: got %b, required 00", resp); end
        aw_dly = 0;
        do_cmd(1'b1, 32'h8000_0004, 32'h0, 4'h0, lat2, resp, rd, to);
        vec++; if (rd !== 32'hDEAD_BEEF) begin miscmp++;
            $display("FAIL split_readback0: got %h, required deadbeef", rd); end
        do_cmd(1'b1, 32'h8000_0008, 32'h0, 4'h0, lat2, resp, rd, to);
        vec++; if (rd !== 32'h0BAD_F00D) begin miscmp++;
            $display("FAIL split_readback1: got %h, required 0badf00d", rd); end
    endtask

    task automatic test_decerr();
        int lat; logic [1:0] resp; logic [31:0] rd; logic to;
        do_cmd(1'b1, 32'h8000_1000, 32'h0, 4'h0, lat, resp, rd, to);
        vec++; if ({resp, to, rd} !== {AXI4L_RESP_DECERR, 1'b0, 32'h0}) begin miscmp++;
            $display("FAIL decerr: got resp=%b to=%b rdata=%h, required 11 0 00000000", resp, to, rd); end
    endtask

    task automatic test_backpressure();
        int acc, seen, m; bit stable; logic [1:0] resp0;
        send_cmd(1'b0, 32'h8000_000C, 32'h1234_5678, 4'hF, acc);
        wait_rsp(seen);
        resp0 = rsp_resp;
        cmd_rnw = 1'b1; cmd_addr = 32'h8000_000C; cmd_wstrb = 4'h0; cmd_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || rsp_resp !== resp0 || rsp_rdata !== 32'h0 || rsp_timeout || cmd_ready)
                stable = 1'b0;
            @(negedge clk);
        end
        vec++; if (stable !== 1'b1) begin miscmp++;
            $display("FAIL bp_hold: rsp not held or cmd_ready rose, got stable=%b, required 1", stable); end
        vec++; if ({rsp_valid, rsp_resp, cmd_ready} !== {1'b1, AXI4L_RESP_OKAY, 1'b0}) begin miscmp++;
            $display("FAIL bp_final: got valid=%b resp=%b cmd_ready=%b, required 1 00 0",
                rsp_valid, rsp_resp, cmd_ready); end
        m = cyc;
        consume();
        @(negedge clk);
        vec++; if ({cmd_ready, rsp_valid, cyc - m} !== {1'b1, 1'b0, 32'd1}) begin miscmp++;
            $display("FAIL bp_next_accept: got cmd_ready=%b rsp_valid=%b, required 1 0 one cycle after rsp handshake",
                cmd_ready, rsp_valid); end
        acc = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_rsp(seen);
        vec++; if ({rsp_rdata, rsp_resp, seen - acc} !== {32'h1234_5678, AXI4L_RESP_OKAY, 32'd3}) begin miscmp++;
            $display("FAIL bp_read: got rdata=%h resp=%b lat=%0d, required 12345678 00 3",
                rsp_rdata, rsp_resp, seen - acc); end
        consume();
    endtask

    task automatic test_timeout();
        int acc, seen, ar_hi;
        ar_block = 1'b1; ar_hi = 0; seen = -1;
        send_cmd(1'b1, 32'h8000_0010, 32'h0, 4'h0, acc);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = cyc;
                break;
            end
            if (m_axi_arvalid) ar_hi++;
        end
        vec++; if ({ar_hi, seen - acc} !== {32'd16, 32'd17}) begin miscmp++;
            $display("FAIL timeout_arvalid: got ar_hi=%0d lat=%0d, required 16 17", ar_hi, seen - acc); end
        vec++; if ({rsp_resp, rsp_timeout, rsp_rdata, m_axi_arvalid, m_axi_rready} !==
                   {AXI4L_RESP_SLVERR, 1'b1, 32'h0, 1'b0, 1'b0}) begin miscmp++;
            $display("FAIL timeout_rsp: got resp=%b to=%b rdata=%h arvalid=%b rready=%b, required 10 1 00000000 0 0",
                rsp_resp, rsp_timeout, rsp_rdata, m_axi_arvalid, m_axi_rready); end
        consume();
        ar_block = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc, lat; bit quiet; logic [1:0] resp; logic [31:0] rd; logic to;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        aw_dly = 8; w_dly = 8;
        send_cmd(1'b0, 32'h8000_0014, 32'h0BAD_0BAD, 4'hF, acc);
        repeat (2) @(negedge clk);
        vec++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin miscmp++;
            $display("FAIL mid_pre: got awvalid=%b wvalid=%b, required 1 1", m_axi_awvalid, m_axi_wvalid); end
        rstn = 1'b0;
        #1;
        vec++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                    cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !== 42'h0) begin miscmp++;
            $display("FAIL mid_reset: got aw=%b w=%b ar=%b b=%b r=%b cr=%b rv=%b rdata=%h resp=%b to=%b, required all 0",
                m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout); end
        aw_dly = 0; w_dly = 0;
        @(negedge clk);
        rstn = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || m_axi_awvalid || m_axi_wvalid) quiet = 1'b0;
        end
        vec++; if (quiet !== 1'b1) begin miscmp++;
            $display("FAIL mid_no_rsp: got activity after reset, required none"); end
        do_cmd(1'b0, 32'h8000_0014, 32'hCAFE_F00D, 4'hF, lat, resp, rd, to);
        vec++; if ({resp, to, lat} !== {AXI4L_RESP_OKAY, 1'b0, 32'd3}) begin miscmp++;
            $display("FAIL mid_after_wr: got resp=%b to=%b lat=%0d, required 00 0 3", resp, to, lat); end
        do_cmd(1'b1, 32'h8000_0014, 32'h0, 4'h0, lat, resp, rd, to);
        vec++; if ({rd, resp} !== {32'hCAFE_F00D, AXI4L_RESP_OKAY}) begin miscmp++;
            $display("FAIL mid_after_rd: got rdata=%h resp=%b, required cafef00d 00", rd, resp); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_split_write();
        test_decerr();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
